// File: rtl/sys_defs.sv
// Shared core definitions: machine widths and the decoded packet that travels
// from dispatch through the reservation station to execute.
package sys_defs;

    localparam int XLEN   = 32;
    localparam int PRF    = 64;
    localparam int ROB    = 16;
    localparam int RS     = 16;
    localparam int WAYS   = 3;

    localparam int LOGPRF = $clog2(PRF);
    localparam int LOGROB = $clog2(ROB);
    localparam int FREE_W = $clog2(RS) + 1;
    localparam int CNT_W  = $clog2(WAYS) + 1;
    localparam int WAY_W  = $clog2(WAYS);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [3:0]      alu_func;
        logic            valid;
    } ID_EX_PACKET;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } cdb_hit_t;

    // Tag lookup against all CDB ports; the lowest matching port wins.
    function automatic cdb_hit_t cdb_lookup(
        input logic [LOGPRF-1:0]            tag,
        input logic [WAYS-1:0][LOGPRF-1:0]  cdb_tag,
        input logic [WAYS-1:0][XLEN-1:0]    cdb_data,
        input logic [WAYS-1:0]              cdb_valid
    );
        cdb_hit_t r;
        r = '0;
        for (int p = WAYS - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p] == tag) begin
                r.hit  = 1'b1;
                r.data = cdb_data[p];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: holds a renamed instruction, captures operands
// from the CDB at dispatch (bypass) and while waiting (wakeup).
module rs_entry
    import sys_defs::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           i_load,
    input  logic                           i_clear,
    input  ID_EX_PACKET                    i_packet,
    input  logic                           i_opa_valid,
    input  logic                           i_opb_valid,
    input  logic [LOGPRF-1:0]              i_dest,
    input  logic [LOGROB-1:0]              i_rob,
    input  logic [WAYS-1:0][XLEN-1:0]      i_cdb_data,
    input  logic [WAYS-1:0][LOGPRF-1:0]    i_cdb_tag,
    input  logic [WAYS-1:0]                i_cdb_valid,
    output logic                           o_busy,
    output logic                           o_ready,
    output ID_EX_PACKET                    o_packet,
    output logic [LOGPRF-1:0]              o_dest,
    output logic [LOGROB-1:0]              o_rob
);

    logic              r_busy;
    ID_EX_PACKET       r_packet;
    logic [XLEN-1:0]   r_opa_val, r_opb_val;
    logic              r_opa_rdy, r_opb_rdy;
    logic [LOGPRF-1:0] r_opa_tag, r_opb_tag;
    logic [LOGPRF-1:0] r_dest;
    logic [LOGROB-1:0] r_rob;

    cdb_hit_t w_in_a, w_in_b, w_wake_a, w_wake_b;

    assign w_in_a   = cdb_lookup(i_packet.rs1_value[LOGPRF-1:0], i_cdb_tag, i_cdb_data, i_cdb_valid);
    assign w_in_b   = cdb_lookup(i_packet.rs2_value[LOGPRF-1:0], i_cdb_tag, i_cdb_data, i_cdb_valid);
    assign w_wake_a = cdb_lookup(r_opa_tag, i_cdb_tag, i_cdb_data, i_cdb_valid);
    assign w_wake_b = cdb_lookup(r_opb_tag, i_cdb_tag, i_cdb_data, i_cdb_valid);

    // NOTE: state uses non-blocking assignments so every slot samples the same pre-edge values.
    // NOTE: the payload is cleared too, so issued/idle outputs never carry stale data after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_packet  <= '0;
            r_opa_val <= '0;
            r_opb_val <= '0;
            r_opa_rdy <= 1'b0;
            r_opb_rdy <= 1'b0;
            r_opa_tag <= '0;
            r_opb_tag <= '0;
            r_dest    <= '0;
            r_rob     <= '0;
        end else if (i_load) begin
            r_busy    <= 1'b1;
            r_packet  <= i_packet;
            r_opa_tag <= i_packet.rs1_value[LOGPRF-1:0];
            r_opb_tag <= i_packet.rs2_value[LOGPRF-1:0];
            r_opa_rdy <= i_opa_valid | w_in_a.hit;
            r_opb_rdy <= i_opb_valid | w_in_b.hit;
            r_opa_val <= i_opa_valid ? i_packet.rs1_value : w_in_a.data;
            r_opb_val <= i_opb_valid ? i_packet.rs2_value : w_in_b.data;
            r_dest    <= i_dest;
            r_rob     <= i_rob;
        end else if (i_clear) begin
            r_busy    <= 1'b0;
            r_opa_rdy <= 1'b0;
            r_opb_rdy <= 1'b0;
        end else if (r_busy) begin
            if (!r_opa_rdy && w_wake_a.hit) begin
                r_opa_rdy <= 1'b1;
                r_opa_val <= w_wake_a.data;
            end
            if (!r_opb_rdy && w_wake_b.hit) begin
                r_opb_rdy <= 1'b1;
                r_opb_val <= w_wake_b.data;
            end
        end
    end

    always_comb begin
        o_packet           = r_packet;
        o_packet.rs1_value = r_opa_val;
        o_packet.rs2_value = r_opb_val;
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy & r_opa_rdy & r_opb_rdy;
    assign o_dest  = r_dest;
    assign o_rob   = r_rob;

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: lowest-free-first allocation of up to WAYS
// dispatches, lowest-index-first issue of up to WAYS ready entries, free count.
module reservation_station
    import sys_defs::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WAYS-1:0][XLEN-1:0]      CDB_Data,
    input  logic [WAYS-1:0][LOGPRF-1:0]    CDB_PRF_idx,
    input  logic [WAYS-1:0]                CDB_valid,
    input  logic [WAYS-1:0]                opa_valid_in,
    input  logic [WAYS-1:0]                opb_valid_in,
    input  logic [WAYS-1:0][LOGPRF-1:0]    dest_PRF_idx_in,
    input  logic [WAYS-1:0][LOGROB-1:0]    rob_idx_in,
    input  ID_EX_PACKET [WAYS-1:0]         id_rs_packet_in,
    input  logic                           load_in,
    output ID_EX_PACKET [WAYS-1:0]         rs_packet_out,
    output logic [WAYS-1:0]                inst_out_valid,
    output logic [WAYS-1:0][LOGPRF-1:0]    dest_PRF_idx_out,
    output logic [WAYS-1:0][LOGROB-1:0]    rob_idx_out,
    output logic [FREE_W-1:0]              num_is_free,
    output logic [CNT_W-1:0]               free_decrease,
    output logic [CNT_W-1:0]               free_increase,
    output logic [FREE_W-1:0]              num_is_free_next,
    output logic [RS-1:0]                  is_free_hub,
    output logic [RS-1:0]                  ready_hub,
    output logic [RS-1:0]                  reset_hub
);

    logic [RS-1:0]             w_busy, w_ready, w_load, w_sel;
    logic [RS-1:0][WAY_W-1:0]  w_load_way;
    ID_EX_PACKET [RS-1:0]      w_pkt;
    logic [RS-1:0][LOGPRF-1:0] w_dest;
    logic [RS-1:0][LOGROB-1:0] w_rob;
    logic [CNT_W-1:0]          w_dec, w_inc;
    logic [FREE_W-1:0]         r_num_is_free;

    for (genvar e = 0; e < RS; e++) begin : g_entry
        rs_entry u_entry (
            .clock       (clock),
            .reset       (reset),
            .i_load      (w_load[e]),
            .i_clear     (w_sel[e]),
            .i_packet    (id_rs_packet_in[w_load_way[e]]),
            .i_opa_valid (opa_valid_in[w_load_way[e]]),
            .i_opb_valid (opb_valid_in[w_load_way[e]]),
            .i_dest      (dest_PRF_idx_in[w_load_way[e]]),
            .i_rob       (rob_idx_in[w_load_way[e]]),
            .i_cdb_data  (CDB_Data),
            .i_cdb_tag   (CDB_PRF_idx),
            .i_cdb_valid (CDB_valid),
            .o_busy      (w_busy[e]),
            .o_ready     (w_ready[e]),
            .o_packet    (w_pkt[e]),
            .o_dest      (w_dest[e]),
            .o_rob       (w_rob[e])
        );
    end

    // Entries being issued are still busy here, so they are not reused until next cycle.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin : alloc
        logic [RS-1:0] taken;
        logic          placed;
        taken      = w_busy;
        placed     = 1'b0;
        w_load     = '0;
        w_load_way = '0;
        w_dec      = '0;
        for (int w = 0; w < WAYS; w++) begin
            placed = 1'b0;
            if (reset && load_in && id_rs_packet_in[w].valid) begin
                for (int e = 0; e < RS; e++) begin
                    if (!placed && !taken[e]) begin
                        placed        = 1'b1;
                        taken[e]      = 1'b1;
                        w_load[e]     = 1'b1;
                        w_load_way[e] = WAY_W'(w);
                        w_dec         = w_dec + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin : issue
        logic [CNT_W-1:0] n;
        n                = '0;
        w_sel            = '0;
        inst_out_valid   = '0;
        rs_packet_out    = '0;
        dest_PRF_idx_out = '0;
        rob_idx_out      = '0;
        for (int e = 0; e < RS; e++) begin
            if (ready_hub[e] && n < CNT_W'(WAYS)) begin
                w_sel[e]            = 1'b1;
                inst_out_valid[n]   = 1'b1;
                rs_packet_out[n]    = w_pkt[e];
                dest_PRF_idx_out[n] = w_dest[e];
                rob_idx_out[n]      = w_rob[e];
                n                   = n + CNT_W'(1);
            end
        end
        w_inc = n;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_num_is_free <= FREE_W'(RS);
        end else begin
            r_num_is_free <= num_is_free_next;
        end
    end

    assign is_free_hub      = ~w_busy;
    assign ready_hub        = w_ready & {RS{reset}};
    assign reset_hub        = w_sel;
    assign free_decrease    = w_dec;
    assign free_increase    = w_inc;
    assign num_is_free      = r_num_is_free;
    assign num_is_free_next = reset ? (r_num_is_free - FREE_W'(w_dec) + FREE_W'(w_inc))
                                    : FREE_W'(RS);

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: a slot-array model driven from
// the allocation/wakeup/issue rules, directed scenarios plus random traffic.
module tb_reservation_station;
    import sys_defs::*;

    logic                        clock, reset;
    logic [WAYS-1:0][XLEN-1:0]   CDB_Data;
    logic [WAYS-1:0][LOGPRF-1:0] CDB_PRF_idx;
    logic [WAYS-1:0]             CDB_valid;
    logic [WAYS-1:0]             opa_valid_in, opb_valid_in;
    logic [WAYS-1:0][LOGPRF-1:0] dest_PRF_idx_in;
    logic [WAYS-1:0][LOGROB-1:0] rob_idx_in;
    ID_EX_PACKET [WAYS-1:0]      id_rs_packet_in;
    logic                        load_in;
    ID_EX_PACKET [WAYS-1:0]      rs_packet_out;
    logic [WAYS-1:0]             inst_out_valid;
    logic [WAYS-1:0][LOGPRF-1:0] dest_PRF_idx_out;
    logic [WAYS-1:0][LOGROB-1:0] rob_idx_out;
    logic [FREE_W-1:0]           num_is_free, num_is_free_next;
    logic [CNT_W-1:0]            free_decrease, free_increase;
    logic [RS-1:0]               is_free_hub, ready_hub, reset_hub;

    reservation_station dut (
        .clock(clock), .reset(reset),
        .CDB_Data(CDB_Data), .CDB_PRF_idx(CDB_PRF_idx), .CDB_valid(CDB_valid),
        .opa_valid_in(opa_valid_in), .opb_valid_in(opb_valid_in),
        .dest_PRF_idx_in(dest_PRF_idx_in), .rob_idx_in(rob_idx_in),
        .id_rs_packet_in(id_rs_packet_in), .load_in(load_in),
        .rs_packet_out(rs_packet_out), .inst_out_valid(inst_out_valid),
        .dest_PRF_idx_out(dest_PRF_idx_out), .rob_idx_out(rob_idx_out),
        .num_is_free(num_is_free), .free_decrease(free_decrease),
        .free_increase(free_increase), .num_is_free_next(num_is_free_next),
        .is_free_hub(is_free_hub), .ready_hub(ready_hub), .reset_hub(reset_hub)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: what each slot holds, independent of how the RTL stores it.
    ID_EX_PACKET       m_pkt  [RS];
    bit                m_busy [RS];
    bit                m_ar   [RS];
    bit                m_br   [RS];
    logic [XLEN-1:0]   m_av   [RS];
    logic [XLEN-1:0]   m_bv   [RS];
    logic [LOGPRF-1:0] m_at   [RS];
    logic [LOGPRF-1:0] m_bt   [RS];
    logic [LOGPRF-1:0] m_dest [RS];
    logic [LOGROB-1:0] m_rob  [RS];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lookup(input logic [LOGPRF-1:0] tag, output logic [XLEN-1:0] data);
        data = '0;
        for (int p = 0; p < WAYS; p++)
            if (CDB_valid[p] && CDB_PRF_idx[p] == tag) begin
                data = CDB_Data[p];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic compare();
        int free, req, dec, n;
        logic [RS-1:0] rdy, iss, fr;
        ID_EX_PACKET p;
        if (!reset) begin
            check("rst_valid", 160'(inst_out_valid), 160'(0));
            check("rst_dec", 160'(free_decrease), 160'(0));
            check("rst_inc", 160'(free_increase), 160'(0));
            check("rst_next", 160'(num_is_free_next), 160'(RS));
            return;
        end
        free = 0;
        for (int e = 0; e < RS; e++) begin
            fr[e]  = !m_busy[e];
            rdy[e] = m_busy[e] && m_ar[e] && m_br[e];
            if (!m_busy[e]) free++;
        end
        n = 0;
        iss = '0;
        for (int e = 0; e < RS; e++) begin
            if (rdy[e] && n < WAYS) begin
                iss[e] = 1'b1;
                p = m_pkt[e];
                p.rs1_value = m_av[e];
                p.rs2_value = m_bv[e];
                check($sformatf("slot%0d_valid", n), 160'(inst_out_valid[n]), 160'(1));
                check($sformatf("slot%0d_pkt", n), 160'(rs_packet_out[n]), 160'(p));
                check($sformatf("slot%0d_dest", n), 160'(dest_PRF_idx_out[n]), 160'(m_dest[e]));
                check($sformatf("slot%0d_rob", n), 160'(rob_idx_out[n]), 160'(m_rob[e]));
                n++;
            end
        end
        for (int s = n; s < WAYS; s++) begin
            check($sformatf("slot%0d_idle_valid", s), 160'(inst_out_valid[s]), 160'(0));
            check($sformatf("slot%0d_idle_pkt", s), 160'(rs_packet_out[s]), 160'(0));
            check($sformatf("slot%0d_idle_dest", s), 160'(dest_PRF_idx_out[s]), 160'(0));
            check($sformatf("slot%0d_idle_rob", s), 160'(rob_idx_out[s]), 160'(0));
        end
        req = 0;
        if (load_in)
            for (int w = 0; w < WAYS; w++) if (id_rs_packet_in[w].valid) req++;
        dec = (req < free) ? req : free;
        check("num_is_free", 160'(num_is_free), 160'(free));
        check("is_free_hub", 160'(is_free_hub), 160'(fr));
        check("ready_hub", 160'(ready_hub), 160'(rdy));
        check("reset_hub", 160'(reset_hub), 160'(iss));
        check("free_decrease", 160'(free_decrease), 160'(dec));
        check("free_increase", 160'(free_increase), 160'(n));
        check("num_is_free_next", 160'(num_is_free_next), 160'(free - dec + n));
    endtask

    task automatic model_edge();
        bit pre_free[RS];
        bit taken[RS];
        logic [XLEN-1:0] d;
        int n;
        if (!reset) begin
            for (int e = 0; e < RS; e++) begin
                m_busy[e] = 0; m_ar[e] = 0; m_br[e] = 0;
            end
            return;
        end
        for (int e = 0; e < RS; e++) begin
            pre_free[e] = !m_busy[e];
            taken[e] = 0;
        end
        n = 0;
        for (int e = 0; e < RS; e++)
            if (m_busy[e] && m_ar[e] && m_br[e] && n < WAYS) begin
                m_busy[e] = 0;
                n++;
            end
        for (int e = 0; e < RS; e++) begin
            if (m_busy[e] && !m_ar[e] && lookup(m_at[e], d)) begin m_ar[e] = 1; m_av[e] = d; end
            if (m_busy[e] && !m_br[e] && lookup(m_bt[e], d)) begin m_br[e] = 1; m_bv[e] = d; end
        end
        if (load_in)
            for (int w = 0; w < WAYS; w++) begin
                if (!id_rs_packet_in[w].valid) continue;
                for (int e = 0; e < RS; e++) begin
                    if (pre_free[e] && !taken[e]) begin
                        taken[e]  = 1;
                        m_busy[e] = 1;
                        m_pkt[e]  = id_rs_packet_in[w];
                        m_dest[e] = dest_PRF_idx_in[w];
                        m_rob[e]  = rob_idx_in[w];
                        m_at[e]   = id_rs_packet_in[w].rs1_value[LOGPRF-1:0];
                        m_bt[e]   = id_rs_packet_in[w].rs2_value[LOGPRF-1:0];
                        m_ar[e]   = opa_valid_in[w] ? 1'b1 : lookup(m_at[e], d);
                        m_av[e]   = opa_valid_in[w] ? id_rs_packet_in[w].rs1_value : d;
                        m_br[e]   = opb_valid_in[w] ? 1'b1 : lookup(m_bt[e], d);
                        m_bv[e]   = opb_valid_in[w] ? id_rs_packet_in[w].rs2_value : d;
                        break;
                    end
                end
            end
    endtask

    // One cycle: compare at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        @(negedge clock);
        compare();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        CDB_Data = '0; CDB_PRF_idx = '0; CDB_valid = '0;
        opa_valid_in = '0; opb_valid_in = '0;
        dest_PRF_idx_in = '0; rob_idx_in = '0;
        id_rs_packet_in = '0; load_in = 1'b0;
    endtask

    task automatic set_way(input int w, input logic av, input logic [XLEN-1:0] a,
                           input logic bv, input logic [XLEN-1:0] b,
                           input logic [LOGPRF-1:0] d, input logic [LOGROB-1:0] r);
        id_rs_packet_in[w].valid     = 1'b1;
        id_rs_packet_in[w].inst      = $urandom;
        id_rs_packet_in[w].PC        = $urandom;
        id_rs_packet_in[w].alu_func  = 4'($urandom);
        id_rs_packet_in[w].rs1_value = a;
        id_rs_packet_in[w].rs2_value = b;
        opa_valid_in[w]    = av;
        opb_valid_in[w]    = bv;
        dest_PRF_idx_in[w] = d;
        rob_idx_in[w]      = r;
    endtask

    task automatic set_cdb(input int p, input logic [LOGPRF-1:0] tag, input logic [XLEN-1:0] data);
        CDB_valid[p]   = 1'b1;
        CDB_PRF_idx[p] = tag;
        CDB_Data[p]    = data;
    endtask

    task automatic idle(input int cycles);
        clear_inputs();
        for (int i = 0; i < cycles; i++) step();
    endtask

    int order[15] = '{15, 8, 3, 1, 2, 14, 5, 9, 12, 4, 6, 7, 10, 11, 13};

    initial begin
        logic [LOGPRF-1:0] t;
        logic [LOGPRF-1:0] used[WAYS];
        bit dup;

        reset = 1'b0;
        clear_inputs();
        @(posedge clock); #1;
        step();
        reset = 1'b1;
        check("reset_num_is_free", 160'(num_is_free), 160'(16));
        check("reset_inst_out_valid", 160'(inst_out_valid), 160'(0));
        check("reset_is_free_hub", 160'(is_free_hub), 160'(16'hffff));

        // Dispatch with bypass of tag 0 on CDB port 0.
        set_way(0, 1'b1, 32'd1, 1'b0, 32'd0, 6'd10, 4'd0);
        set_way(1, 1'b1, 32'd3, 1'b0, 32'd2, 6'd11, 4'd1);
        set_way(2, 1'b1, 32'd5, 1'b0, 32'd4, 6'd12, 4'd2);
        load_in = 1'b1;
        set_cdb(0, 6'd0, 32'habc);
        step();
        clear_inputs();
        check("disp_num_is_free", 160'(num_is_free), 160'(13));
        check("disp_issue_valid", 160'(inst_out_valid), 160'(3'b001));
        check("disp_issue_rs2", 160'(rs_packet_out[0].rs2_value), 160'(32'habc));
        check("disp_issue_rs1", 160'(rs_packet_out[0].rs1_value), 160'(32'd1));
        step();
        set_cdb(0, 6'd2, 32'h222);
        set_cdb(1, 6'd4, 32'h444);
        step();
        clear_inputs();
        check("wake_issue_valid", 160'(inst_out_valid), 160'(3'b011));
        check("wake_issue_rs2", 160'(rs_packet_out[1].rs2_value), 160'(32'h444));
        idle(3);
        check("disp_drained", 160'(num_is_free), 160'(16));

        // Ships in the night: steady three-wide flow.
        for (int i = 0; i < 100; i++) begin
            clear_inputs();
            t = LOGPRF'($urandom);
            load_in = 1'b1;
            set_way(0, 1'b1, $urandom, 1'b1, $urandom, LOGPRF'($urandom), LOGROB'($urandom));
            set_way(1, 1'b1, $urandom, 1'b1, $urandom, LOGPRF'($urandom), LOGROB'($urandom));
            set_way(2, 1'b1, $urandom, 1'b0, {26'($urandom), t}, LOGPRF'($urandom), LOGROB'($urandom));
            set_cdb(1, t, $urandom);
            step();
            check("steady_num_is_free", 160'(num_is_free), 160'(13));
            check("steady_issue_valid", 160'(inst_out_valid), 160'(3'b111));
        end
        idle(3);

        // Selector: 15 pending entries woken three tags per cycle, out of order.
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            load_in = 1'b1;
            for (int w = 0; w < WAYS; w++)
                set_way(w, 1'b0, XLEN'(c * 3 + w + 1), 1'b1, $urandom,
                        LOGPRF'($urandom), LOGROB'($urandom));
            step();
        end
        check("sel_filled", 160'(num_is_free), 160'(1));
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            for (int p = 0; p < WAYS; p++) set_cdb(p, LOGPRF'(order[c * 3 + p]), $urandom);
            step();
        end
        idle(8);
        check("sel_drained", 160'(num_is_free), 160'(16));

        // Full: tags 62/63 are never broadcast.
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            load_in = 1'b1;
            for (int w = 0; w < WAYS; w++)
                set_way(w, 1'b0, 32'd63, 1'b0, 32'd62, LOGPRF'($urandom), LOGROB'($urandom));
            step();
        end
        check("full_one_left", 160'(num_is_free), 160'(1));
        step();
        check("full_zero", 160'(num_is_free), 160'(0));
        check("full_no_alloc", 160'(free_decrease), 160'(0));
        step();
        check("full_stays_zero", 160'(num_is_free), 160'(0));

        // Reset overrides a load and wakeup in the same cycle.
        set_cdb(0, 6'd63, 32'h1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_inputs();
        check("rst_override_free", 160'(num_is_free), 160'(16));
        check("rst_override_hub", 160'(is_free_hub), 160'(16'hffff));

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            clear_inputs();
            reset = ($urandom_range(0, 199) != 0);
            load_in = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < WAYS; w++)
                if ($urandom_range(0, 3) != 0)
                    set_way(w, ($urandom_range(0, 2) == 0), {26'($urandom), 6'($urandom_range(0, 15))},
                            ($urandom_range(0, 2) == 0), {26'($urandom), 6'($urandom_range(0, 15))},
                            LOGPRF'($urandom), LOGROB'($urandom));
            for (int p = 0; p < WAYS; p++) begin
                used[p] = LOGPRF'($urandom_range(0, 15));
                dup = 0;
                for (int q = 0; q < p; q++) if (CDB_valid[q] && used[q] == used[p]) dup = 1;
                if (!dup && $urandom_range(0, 1) == 1) set_cdb(p, used[p], $urandom);
            end
            step();
        end
        reset = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
